serial_chunk_adder: RTL

//  Multi-cycle, parametrised ripple-carry adder/subtractor built from full-adder cells.

---
 rtl/serial_chunk_adder_pkg.sv | 18 +
 rtl/serial_chunk_adder_chunk.sv | 23 ++
 rtl/serial_chunk_adder.sv | 107 ++++++++++
 3 files changed

// File: rtl/serial_chunk_adder_pkg.sv
// rtl/serial_chunk_adder_pkg.sv - shared FSM encoding and sizing helper for serial_chunk_adder
package serial_chunk_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_chunk_adder_chunk.sv
// rtl/serial_chunk_adder_chunk.sv - combinational CHUNK-bit ripple of full-adder cells
module adder_chunk #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  always_comb begin : b_ripple
    logic c;
    sum = '0;
    c   = cin;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/serial_chunk_adder.sv
// rtl/serial_chunk_adder.sv - multi-cycle add/subtract, CHUNK bits per clock, LSB chunk first
module serial_chunk_adder
  import serial_chunk_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
    $error("serial_chunk_adder: WIDTH must be a nonzero multiple of CHUNK");
  end

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_r, b_r;
  logic [CHUNK-1:0] a_ch, b_ch, s_ch;
  logic             c_out;
  logic             accept;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  always_comb begin
    a_ch = '0;
    b_ch = '0;
    for (int i = 0; i < N; i++) begin
      if (cnt == CW'(i)) begin
        a_ch = a_r[i*CHUNK +: CHUNK];
        b_ch = b_r[i*CHUNK +: CHUNK];
      end
    end
  end

  adder_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a    (a_ch),
    .b    (b_ch),
    .cin  (carry),
    .sum  (s_ch),
    .cout (c_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // b is stored already inverted for subtract so RUN only ever adds
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      carry <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_r   <= a;
      b_r   <= op_sub ? ~b : b;
      carry <= op_sub ? 1'b1 : cin;
      cnt   <= '0;
      sum   <= '0;
    end else if (state == RUN) begin
      for (int i = 0; i < N; i++) begin
        if (cnt == CW'(i)) sum[i*CHUNK +: CHUNK] <= s_ch;
      end
      carry <= c_out;
      if (cnt == LAST) begin
        cout <= c_out;
        ovf  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (s_ch[CHUNK-1] != a_r[WIDTH-1]);
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
